// File: rtl/prince_sbox_cms_compress.sv
// Mask-refresh and share-compression stage behind the three-share PRINCE CMS S-box.
// The nine shares per bit are refreshed and registered, then folded into three shares.
module prince_sbox_cms_compress #(
  parameter int BITS   = 4,
  parameter int SH_IN  = 9,
  parameter int SH_OUT = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [BITS*SH_IN-1:0]    in_shares,
  input  logic [BITS*SH_IN-1:0]    rnd,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [BITS*SH_OUT-1:0]   out_shares
);

  localparam int NI  = BITS * SH_IN;
  localparam int NO  = BITS * SH_OUT;
  localparam int GRP = SH_IN / SH_OUT;

  // Ring refresh: each mask enters two neighbouring shares, so it cancels in the bit sum.
  function automatic logic [NI-1:0] refresh(input logic [NI-1:0] sh, input logic [NI-1:0] r);
    logic [NI-1:0] res;
    res = '0;
    for (int b = 0; b < BITS; b++) begin
      for (int j = 0; j < SH_IN; j++) begin
        res[b*SH_IN+j] = sh[b*SH_IN+j] ^ r[b*SH_IN+j] ^ r[b*SH_IN+((j+1)%SH_IN)];
      end
    end
    return res;
  endfunction

  function automatic logic [NO-1:0] compress(input logic [NI-1:0] s);
    logic [NO-1:0] res;
    res = '0;
    for (int b = 0; b < BITS; b++) begin
      for (int k = 0; k < SH_OUT; k++) begin
        for (int m = 0; m < GRP; m++) begin
          res[b*SH_OUT+k] = res[b*SH_OUT+k] ^ s[b*SH_IN+k*GRP+m];
        end
      end
    end
    return res;
  endfunction

  logic          vld_p1_q, vld_p1_d;
  logic          vld_p2_q, vld_p2_d;
  logic [NI-1:0] shares_p1_q, shares_p1_d;
  logic [NO-1:0] shares_p2_q, shares_p2_d;
  logic          en_p1, en_p2, accept;

  assign en_p2    = !vld_p2_q || out_ready;
  assign en_p1    = !vld_p1_q || en_p2;
  assign in_ready = en_p1;
  assign accept   = in_valid && en_p1;

  always_comb begin
    vld_p1_d    = vld_p1_q;
    shares_p1_d = shares_p1_q;
    vld_p2_d    = vld_p2_q;
    shares_p2_d = shares_p2_q;
    if (accept) begin
      vld_p1_d    = 1'b1;
      shares_p1_d = refresh(in_shares, rnd);
    end else if (en_p2) begin
      vld_p1_d    = 1'b0;
    end
    if (en_p2) begin
      vld_p2_d = vld_p1_q;
      if (vld_p1_q) shares_p2_d = compress(shares_p1_q);
    end
  end

  // Stage 1: refreshed shares (glitch barrier); stage 2: compressed output shares.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1_q    <= 1'b0;
      vld_p2_q    <= 1'b0;
      shares_p1_q <= '0;
      shares_p2_q <= '0;
    end else begin
      vld_p1_q    <= vld_p1_d;
      vld_p2_q    <= vld_p2_d;
      shares_p1_q <= shares_p1_d;
      shares_p2_q <= shares_p2_d;
    end
  end

  assign out_valid  = vld_p2_q;
  assign out_shares = shares_p2_q;

endmodule
